// File: rtl/types_pkg.sv
// Shared types and constants for the dispatch stage: FU encodings, physical
// register file sizing and the renamed-instruction record.
package types_pkg;

    localparam int PREG_COUNT     = 128;
    localparam int PREG_W         = 7;
    localparam int DISPATCH_DEPTH = 2;
    localparam int CDB_PORTS      = 3;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_BR  = 2'd1;
    localparam logic [1:0] FU_MEM = 2'd2;

    typedef struct packed {
        logic [1:0]        fu;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [11:0]       imm;
    } rename_data;

    // One-hot {mem, br, alu} target; unrecognised encodings fall back to the ALU.
    function automatic logic [2:0] fu_route(input logic [1:0] fu);
        logic [2:0] sel;
        case (fu)
            FU_BR:   sel = 3'b010;
            FU_MEM:  sel = 3'b100;
            default: sel = 3'b001;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/dispatch_preg_ready_table.sv
// Physical-register ready table: CDB completions set bits, dispatch clears the
// new destination. Define DISPATCH_CDB_BYPASS_EN to forward same-cycle CDB sets.
module preg_ready_table
    import types_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CDB_PORTS-1:0]                set_valid,
    input  logic [CDB_PORTS-1:0][PREG_W-1:0]    set_pd,
    input  logic                                clr_valid,
    input  logic [PREG_W-1:0]                   clr_pd,
    output logic [0:PREG_COUNT-1]               rtable
);

    localparam logic [0:PREG_COUNT-1] PREG0_MASK = {1'b1, {(PREG_COUNT-1){1'b0}}};

    logic [0:PREG_COUNT-1] table_r;
    logic [0:PREG_COUNT-1] set_mask_s;
    logic [0:PREG_COUNT-1] clr_mask_s;

    // Decode CDB completions and the dispatch clear into bit masks; preg 0 is never touched.
    always_comb begin
        set_mask_s = '0;
        clr_mask_s = '0;
        for (int k = 0; k < CDB_PORTS; k++) begin
            set_mask_s[set_pd[k]] = set_mask_s[set_pd[k]] |
                                    (set_valid[k] && (set_pd[k] != 7'd0));
        end
        clr_mask_s[clr_pd] = clr_valid && (clr_pd != 7'd0);
    end

    // Table update: clear beats a same-cycle set, preg 0 pinned ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            table_r <= '1;
        end else begin
            table_r <= ((table_r | set_mask_s) & ~clr_mask_s) | PREG0_MASK;
        end
    end

`ifdef DISPATCH_CDB_BYPASS_EN
    assign rtable = table_r | (set_mask_s & ~clr_mask_s);
`else
    assign rtable = table_r;
`endif

endmodule

// File: rtl/dispatch.sv
// Dispatch stage: 2-entry in-order buffer feeding ALU/BR/MEM reservation
// stations plus the preg ready table (optional DISPATCH_CDB_BYPASS_EN).
module dispatch
    import types_pkg::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                r_valid,
    input  rename_data                          r_data,
    output logic                                r_ready,
    input  logic                                rob_full,
    output logic                                rob_alloc,
    input  logic                                rs_full_alu,
    input  logic                                rs_full_br,
    input  logic                                rs_full_mem,
    output logic                                di_en_alu,
    output logic                                di_en_br,
    output logic                                di_en_mem,
    output rename_data                          di_data,
    input  logic [CDB_PORTS-1:0]                cdb_valid,
    input  logic [CDB_PORTS-1:0][PREG_W-1:0]    cdb_pd,
    input  logic                                mispredict,
    output logic [0:PREG_COUNT-1]               preg_rtable
);

    rename_data mem_r [DISPATCH_DEPTH];
    logic       head_r;
    logic       tail_r;
    logic [1:0] count_r;

    rename_data head_s;
    logic [2:0] route_s;
    logic       push_s;
    logic       pop_s;
    logic       has_head_s;

    assign head_s     = mem_r[head_r];
    assign route_s    = fu_route(head_s.fu);
    assign has_head_s = reset && (count_r != 2'd0);
    assign r_ready    = reset && (count_r < 2'd2);
    assign push_s     = r_valid && r_ready && !mispredict;
    assign pop_s      = rob_alloc;
    assign rob_alloc  = di_en_alu | di_en_br | di_en_mem;
    assign di_data    = has_head_s ? head_s : '0;

    // Head-only issue: a blocked head holds back everything behind it.
    always_comb begin
        di_en_alu = 1'b0;
        di_en_br  = 1'b0;
        di_en_mem = 1'b0;
        if (has_head_s && !rob_full && !mispredict) begin
            di_en_alu = route_s[0] && !rs_full_alu;
            di_en_br  = route_s[1] && !rs_full_br;
            di_en_mem = route_s[2] && !rs_full_mem;
        end else begin
            di_en_alu = 1'b0;
            di_en_br  = 1'b0;
            di_en_mem = 1'b0;
        end
    end

    // FIFO pointers and occupancy; a flush empties the buffer and drops the push.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
        end else if (mispredict) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (push_s) begin
                tail_r <= ~tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload storage; validity is tracked by count_r alone.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[tail_r] <= r_data;
        end
    end

    preg_ready_table u_rtable (
        .clk       (clk),
        .reset     (reset),
        .set_valid (cdb_valid),
        .set_pd    (cdb_pd),
        .clr_valid (rob_alloc),
        .clr_pd    (head_s.pd_new),
        .rtable    (preg_rtable)
    );

endmodule

// File: tb/tb_dispatch.sv
// Directed self-checking bench for dispatch: reset, routing, in-order stall,
// ready-table set/clear priority, mispredict flush and reset mid-stall.
module tb_dispatch;
    import types_pkg::*;

    logic                              clk;
    logic                              reset;
    logic                              r_valid;
    rename_data                        r_data;
    logic                              r_ready;
    logic                              rob_full;
    logic                              rob_alloc;
    logic                              rs_full_alu;
    logic                              rs_full_br;
    logic                              rs_full_mem;
    logic                              di_en_alu;
    logic                              di_en_br;
    logic                              di_en_mem;
    rename_data                        di_data;
    logic [CDB_PORTS-1:0]              cdb_valid;
    logic [CDB_PORTS-1:0][PREG_W-1:0]  cdb_pd;
    logic                              mispredict;
    logic [0:PREG_COUNT-1]             preg_rtable;

    int total = 0;
    int bad   = 0;
    logic byp_exp;

    dispatch dut (
        .clk         (clk),
        .reset       (reset),
        .r_valid     (r_valid),
        .r_data      (r_data),
        .r_ready     (r_ready),
        .rob_full    (rob_full),
        .rob_alloc   (rob_alloc),
        .rs_full_alu (rs_full_alu),
        .rs_full_br  (rs_full_br),
        .rs_full_mem (rs_full_mem),
        .di_en_alu   (di_en_alu),
        .di_en_br    (di_en_br),
        .di_en_mem   (di_en_mem),
        .di_data     (di_data),
        .cdb_valid   (cdb_valid),
        .cdb_pd      (cdb_pd),
        .mispredict  (mispredict),
        .preg_rtable (preg_rtable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [1:0] fu, input logic [6:0] pd);
        r_valid       = 1'b1;
        r_data        = '0;
        r_data.fu     = fu;
        r_data.pd_new = pd;
        tick();
        r_valid = 1'b0;
        r_data  = '0;
        #1;
    endtask

    initial begin
        reset = 1'b0; r_valid = 1'b0; r_data = '0; rob_full = 1'b0;
        rs_full_alu = 1'b0; rs_full_br = 1'b0; rs_full_mem = 1'b0;
        cdb_valid = 3'b000; cdb_pd = '0; mispredict = 1'b0;
`ifdef DISPATCH_CDB_BYPASS_EN
        byp_exp = 1'b1;
`else
        byp_exp = 1'b0;
`endif

        // Reset state
        tick(); tick();
        check("rst_r_ready", r_ready, 1'b0);
        check("rst_alloc", rob_alloc, 1'b0);
        check("rst_di_data", di_data, 42'd0);
        check("rst_rtable", preg_rtable, {128{1'b1}});
        reset = 1'b1;
        tick();
        check("rel_r_ready", r_ready, 1'b1);
        check("rel_strobes", {di_en_alu, di_en_br, di_en_mem}, 3'b000);

        // ALU dispatch clears its destination
        push(FU_ALU, 7'd40);
        check("alu_en", di_en_alu, 1'b1);
        check("alu_alloc", rob_alloc, 1'b1);
        check("alu_pd", di_data.pd_new, 7'd40);
        tick();
        check("alu_clr40", preg_rtable[40], 1'b0);
        check("alu_empty_en", di_en_alu, 1'b0);

        // Blocked BR head holds the younger ALU op
        rs_full_br = 1'b1;
        push(FU_BR, 7'd41);
        push(FU_ALU, 7'd42);
        check("stall_r_ready", r_ready, 1'b0);
        check("stall_strobes", {di_en_alu, di_en_br, di_en_mem}, 3'b000);
        check("stall_alloc", rob_alloc, 1'b0);
        rs_full_br = 1'b0;
        #1;
        check("drain1_strobes", {di_en_alu, di_en_br, di_en_mem}, 3'b010);
        check("drain1_pd", di_data.pd_new, 7'd41);
        tick();
        check("drain2_strobes", {di_en_alu, di_en_br, di_en_mem}, 3'b100);
        check("drain2_pd", di_data.pd_new, 7'd42);
        tick();
        check("drain_idle", rob_alloc, 1'b0);
        check("drain_clr", {preg_rtable[41], preg_rtable[42]}, 2'b00);

        // CDB set alone, then set vs clear on the same preg
        cdb_valid = 3'b010; cdb_pd[1] = 7'd40;
        tick();
        cdb_valid = 3'b000;
        #1;
        check("cdb_set40", preg_rtable[40], 1'b1);
        push(FU_ALU, 7'd40);
        cdb_valid = 3'b010; cdb_pd[1] = 7'd40;
        #1;
        check("race_en", di_en_alu, 1'b1);
        tick();
        cdb_valid = 3'b000;
        #1;
        check("race_clear_wins", preg_rtable[40], 1'b0);

        // pd_new = 0 never clears, unknown fu routes to ALU, MEM routing
        push(FU_ALU, 7'd0);
        tick();
        check("preg0_ready", preg_rtable[0], 1'b1);
        push(2'd3, 7'd46);
        check("unk_strobes", {di_en_alu, di_en_br, di_en_mem}, 3'b100);
        tick();
        check("unk_clr46", preg_rtable[46], 1'b0);
        push(FU_MEM, 7'd47);
        check("mem_strobes", {di_en_alu, di_en_br, di_en_mem}, 3'b001);
        tick();

        // Mispredict with a full buffer and a pending push
        rs_full_alu = 1'b1;
        push(FU_ALU, 7'd43);
        push(FU_ALU, 7'd44);
        check("mp_full", r_ready, 1'b0);
        r_valid = 1'b1; r_data = '0; r_data.pd_new = 7'd45;
        mispredict = 1'b1; rs_full_alu = 1'b0;
        #1;
        check("mp_no_strobe", {di_en_alu, di_en_br, di_en_mem}, 3'b000);
        check("mp_no_alloc", rob_alloc, 1'b0);
        tick();
        r_valid = 1'b0; mispredict = 1'b0;
        #1;
        check("mp_empty_ready", r_ready, 1'b1);
        check("mp_empty_alloc", rob_alloc, 1'b0);
        check("mp_empty_data", di_data, 42'd0);
        check("mp_table_kept", {preg_rtable[43], preg_rtable[44], preg_rtable[45]}, 3'b111);

        // CDB wakeup timing with and without bypass
        push(FU_ALU, 7'd55);
        tick();
        check("p55_clr", preg_rtable[55], 1'b0);
        cdb_valid = 3'b001; cdb_pd[0] = 7'd55;
        #1;
        check("p55_same_cycle", preg_rtable[55], byp_exp);
        tick();
        cdb_valid = 3'b000;
        #1;
        check("p55_next_cycle", preg_rtable[55], 1'b1);

        // Reset mid-stall discards the buffered entry
        rs_full_mem = 1'b1;
        push(FU_MEM, 7'd60);
        reset = 1'b0;
        #1;
        check("rst_hold_ready", r_ready, 1'b0);
        check("rst_hold_data", di_data, 42'd0);
        tick();
        rs_full_mem = 1'b0; reset = 1'b1;
        #1;
        check("rel_no_strobe", {di_en_alu, di_en_br, di_en_mem, rob_alloc}, 4'b0000);
        check("rel_table", preg_rtable, {128{1'b1}});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dispatch.md
DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; all state updates on posedge clk.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-003 SHALL have ports: r_valid  in  1  rename output valid; r_data  in  rename_data  renamed instruction; r_ready  out  1  dispatch can accept.
REQ-004 SHALL have ports: rob_full  in  1; rob_alloc  out  1  ROB entry consumed this cycle.
REQ-005 SHALL have ports: rs_full_alu, rs_full_br, rs_full_mem  in  1 each  reservation-station full flags.
REQ-006 SHALL have ports: di_en_alu, di_en_br, di_en_mem  out  1 each  dispatch strobes; di_data  out  rename_data  head instruction.
REQ-007 SHALL have ports: cdb_valid  in  3  per-FU completion; cdb_pd  in  3x7  completing physical destination.
REQ-008 SHALL have ports: mispredict  in  1  flush request; preg_rtable  out  [0:127]x1  physical-register ready table.

Function
REQ-009 SHALL buffer instructions in a 2-entry in-order FIFO (head, tail, 2-bit count).
REQ-010 SHALL drive r_ready = (count < 2), from registered state only; push occurs when r_valid && r_ready.
REQ-011 SHALL route the head by r_data.fu: FU_ALU -> di_en_alu, FU_BR -> di_en_br, FU_MEM -> di_en_mem; unknown fu -> FU_ALU.
REQ-012 SHALL assert the selected di_en_* combinationally when count > 0, target rs_full_* == 0, rob_full == 0, mispredict == 0; at most one di_en_* high per cycle.
REQ-013 SHALL drive rob_alloc identical to the OR of di_en_*; the head pops at the same edge.
REQ-014 SHALL hold di_data = head entry whenever count > 0, and '0 when empty.
REQ-015 SHALL allow simultaneous push and pop; count then unchanged, order preserved.
REQ-016 SHALL stall in order: a blocked head blocks younger entries (no bypass of the head).
REQ-017 SHALL, on mispredict, clear count to 0 at the next edge, drop any push that cycle, and leave preg_rtable unchanged.
REQ-018 SHALL clear ready bit pd_new at the dispatch edge when pd_new != 0.
REQ-019 SHALL set ready bit cdb_pd[k] for every k with cdb_valid[k] and cdb_pd[k] != 0.
REQ-020 SHALL, when a set and a clear hit the same preg in one cycle, keep the clear.
REQ-021 SHALL hold preg_rtable[0] = 1 permanently.

Reset
REQ-022 SHALL on reset == 0 at posedge: count = 0, head = tail = 0, all preg_rtable bits = 1.
REQ-023 SHALL hold during reset: r_ready = 0, di_en_* = 0, rob_alloc = 0, di_data = '0.
REQ-024 SHALL discard buffered entries on reset mid-stall; no dispatch strobe in the cycle after release.

Configuration
REQ-025 SHALL support macro DISPATCH_CDB_BYPASS_EN: when defined, preg_rtable output = registered table OR this-cycle CDB sets (excluding same-cycle clear), so an RS entry dispatched alongside its producer's completion sees the operand ready.
REQ-026 SHALL, when DISPATCH_CDB_BYPASS_EN is undefined, output the registered table only (wakeup one cycle after CDB).

Structure
REQ-027 SHALL place in types_pkg: FU encodings FU_ALU=2'd0, FU_BR=2'd1, FU_MEM=2'd2; PREG_COUNT=128; DISPATCH_DEPTH=2.
REQ-028 SHALL implement the ready table as sub-module preg_ready_table (set ports, clear port, bypass option).

Verification
REQ-029 SHALL verify: reset, then read preg_rtable -> all 128 bits = 1, r_ready = 1 after release.
REQ-030 SHALL verify: push ALU op pd_new=40, RS/ROB not full -> di_en_alu = 1 that cycle, preg_rtable[40] = 0 next cycle.
REQ-031 SHALL verify: rs_full_br = 1, push BR then ALU -> count = 2, r_ready = 0, no strobe; drop rs_full_br -> di_en_br then di_en_alu on consecutive cycles.
REQ-032 SHALL verify: cdb_valid[1]=1, cdb_pd[1]=40 while dispatch clears 40 -> preg_rtable[40] = 0; cdb on 40 alone -> 1.
REQ-033 SHALL verify: count = 2, mispredict = 1 with r_valid = 1 -> count = 0 next cycle, no strobe, no rob_alloc.
REQ-034 SHALL verify: with DISPATCH_CDB_BYPASS_EN, cdb_pd = 55 -> preg_rtable[55] = 1 same cycle; without it, next cycle.
